// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch-state encoding and ROM word layout.
// Used by the fetch unit and the instruction decoder so both agree on encodings.
// No ports; declarations only.
package cpu_pkg;

    localparam logic [7:0] OPC_CLL = 8'h0C;
    localparam logic [7:0] OPC_RET = 8'h0D;
    localparam logic [7:0] OPC_NOP = 8'h13;
    localparam logic [7:0] OPC_RST = 8'h14;

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } fetch_state_e;

    // ROM word layout: opcode in the upper byte, operand in the lower byte
    localparam int ROM_OPC_MSB = 15;
    localparam int ROM_OPC_LSB = 8;
    localparam int ROM_OPR_MSB = 7;
    localparam int ROM_OPR_LSB = 0;

    // Bit positions inside stack_control {PUSH, POP} and stack_flags {FULL, EMPTY}
    localparam int STK_PUSH   = 1;
    localparam int STK_POP    = 0;
    localparam int FLAG_FULL  = 1;
    localparam int FLAG_EMPTY = 0;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: push writes din at sp and increments, pop decrements; dout is top-of-stack.
// Ports: clk, rst (async, active-high), clr (sync clear), push, pop, din, dout, full, empty.
// Push when full and pop when empty are ignored; clr has priority over push/pop.
module ret_stack #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = $clog2(DEPTH);

    logic [SPW-1:0]   sp_q;
    logic [SPW-1:0]   sp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    assign do_push = !clr && push && !full;
    assign do_pop  = !clr && !push && pop && !empty;

    // Top entry sits one below sp; report zero rather than a stale slot when empty
    assign dout = empty ? '0 : mem_q[IDXW'(sp_q - SPW'(1))];

    always_comb begin
        sp_d = sp_q;
        if (clr) begin
            sp_d = '0;
        end else if (do_push) begin
            sp_d = sp_q + SPW'(1);
        end else if (do_pop) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Storage needs no reset: entries above sp are never read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[IDXW'(sp_q)] <= din;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC stage: RESET->FETCH->DECODE->EXEC loop, 3 cycles per instruction.
// Ports: clk, rst, sw_rst, stall; ROM side imem_addr/imem_rd/imem_data; decoder side instr,
// operand, instr_valid, jmp_en, stack_control, stack_flags, stack_err; debug pc. stall holds EXEC.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst,
    input  logic                  stall,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_rd,
    input  logic [15:0]           imem_data,
    output logic [7:0]            instr,
    output logic [7:0]            operand,
    output logic                  instr_valid,
    input  logic                  jmp_en,
    input  logic [1:0]            stack_control,
    output logic [1:0]            stack_flags,
    output logic                  stack_err,
    output logic [ADDR_WIDTH-1:0] pc
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]            instr_q, instr_d;
    logic [7:0]            operand_q, operand_d;
    logic                  err_q, err_d;

    logic                  stk_push, stk_pop, stk_clr;
    logic                  stk_full, stk_empty;
    logic [ADDR_WIDTH-1:0] stk_dout;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] target;

    assign pc_inc = pc_q + ADDR_WIDTH'(1);
    // Size cast zero-extends a narrow operand and truncates a wide one
    assign target = ADDR_WIDTH'(operand_q);

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_WIDTH)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .clr   (stk_clr),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        operand_d = operand_q;
        err_d     = err_q;
        stk_push  = 1'b0;
        stk_pop   = 1'b0;
        stk_clr   = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                state_d   = S_EXEC;
                instr_d   = imem_data[ROM_OPC_MSB:ROM_OPC_LSB];
                operand_d = imem_data[ROM_OPR_MSB:ROM_OPR_LSB];
            end
            S_EXEC: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    if (sw_rst) begin
                        pc_d    = '0;
                        stk_clr = 1'b1;
                        err_d   = 1'b0;
                    end else if (stack_control == 2'b11) begin
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end else if (stack_control[STK_PUSH] && jmp_en) begin
                        stk_push = 1'b1;
                        pc_d     = target;
                    end else if (stack_control[STK_POP]) begin
                        stk_pop = 1'b1;
                        pc_d    = stk_dout;
                    end else if (instr_q == OPC_RET) begin
                        // Decoder withheld POP: stack was empty, skip the return
                        err_d = 1'b1;
                        pc_d  = pc_inc;
                    end else if (instr_q == OPC_CLL) begin
                        // Decoder withheld PUSH: stack was full, jump without link
                        err_d = 1'b1;
                        pc_d  = target;
                    end else if (jmp_en) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET;
            pc_q      <= '0;
            instr_q   <= OPC_NOP;
            operand_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            operand_q <= operand_d;
            err_q     <= err_d;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_rd     = (state_q == S_FETCH);
    assign instr_valid = (state_q == S_EXEC);
    assign instr       = instr_q;
    assign operand     = operand_q;
    assign stack_err   = err_q;
    assign pc          = pc_q;
    assign stack_flags = {stk_full, stk_empty};

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and program-counter stage sitting directly upstream of the instruction decoder.
- Reads 16-bit words from a synchronous program ROM and presents opcode and operand to the decoder.
- Consumes the decoder's jmp_en, stack_control and rst outputs to compute the next PC.
- Owns the call/return address stack and reports its FULL/EMPTY flags back to the decoder.

Parameters:
- ADDR_WIDTH, 8, width of PC and program-memory address.
- STACK_DEPTH, 8, number of return-address entries (must be ≥2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw_rst  in  1  synchronous software reset from the decoder (RST instruction).
- stall  in  1  holds the EXEC state (e.g. slow IO); ignored in other states.
- imem_addr  out  ADDR_WIDTH  program ROM address.
- imem_rd  out  1  program ROM read strobe.
- imem_data  in  16  ROM word, valid one cycle after imem_rd; [15:8] opcode, [7:0] operand.
- instr  out  8  registered opcode to the decoder.
- operand  out  8  registered operand (jump/call target, immediate, register address).
- instr_valid  out  1  high only in EXEC.
- jmp_en  in  1  decoder jump request.
- stack_control  in  2  decoder {PUSH, POP}.
- stack_flags  out  2  {FULL, EMPTY} to the decoder.
- stack_err  out  1  sticky stack fault flag.
- pc  out  ADDR_WIDTH  current PC, for debug.

Behaviour:
- Reset values: state S_RESET, pc=0, instr=NOP (8'h13), operand=0, instr_valid=0, imem_rd=0, imem_addr=0, sp=0, stack_flags=2'b01, stack_err=0.
- Asynchronous reset takes effect immediately in any state and discards any pending push, pop or PC update.
- FSM: S_RESET → S_FETCH (unconditional) → S_DECODE (unconditional) → S_EXEC → S_FETCH.
  - S_FETCH: imem_addr=pc, imem_rd=1.
  - S_DECODE: imem_rd=0; at the clock edge, instr←imem_data[15:8] and operand←imem_data[7:0].
  - S_EXEC: instr_valid=1; decoder outputs are sampled at the end of the cycle.
- Throughput: 3 cycles per instruction when there is no stall.
- While stall=1 in S_EXEC: state, pc, stack and instr are all held.
- End-of-EXEC update (stall=0), evaluated in priority order:
  1. sw_rst: pc=0, sp=0, stack_err=0.
  2. stack_control==2'b11: illegal; set stack_err, pc=pc+1.
  3. PUSH && jmp_en: push pc+1, pc=operand[ADDR_WIDTH-1:0].
  4. POP: pc=top-of-stack, sp decrements.
  5. instr==RET with no POP (stack empty): set stack_err, pc=pc+1.
  6. instr==CLL with no PUSH (stack full): set stack_err, pc=operand; jump without link.
  7. jmp_en: pc=operand.
  8. Otherwise: pc=pc+1.
- PC arithmetic wraps modulo 2^ADDR_WIDTH; a pushed pc+1 wraps the same way.
- Operand is zero-extended when ADDR_WIDTH>8 and truncated when ADDR_WIDTH<8.
- stack_flags are combinational from sp: FULL=(sp==STACK_DEPTH), EMPTY=(sp==0).
- A push when full or a pop when empty never changes sp or the stack contents, whatever the input.
- stack_err stays set until rst or sw_rst.

Decomposition:
- Package cpu_pkg: opcode constants (OPC_CLL=8'h0C, OPC_RET=8'h0D, OPC_NOP=8'h13, OPC_RST=8'h14), fetch-state encoding, ROM field positions. The decoder uses the same constants.
- Sub-module ret_stack: parameterised LIFO with push/pop/din/dout/full/empty and asynchronous reset. fetch_unit instantiates it once.

Test Plan:
- Release rst with ROM[0]={13,00}, ROM[1]={13,00} → imem_rd at cycles 1 and 4; instr_valid at cycles 3 and 6; pc sequence 0,1,2.
- ROM[2]={0A,40}, decoder jmp_en=1 → next imem_addr=0x40; nothing pushed; stack_flags=01.
- CALL at pc=0x10 with target 0x80, then RET at 0x80 → stack holds 0x11, flags 00; after RET pc=0x11, flags 01.
- Nine nested CALLs with STACK_DEPTH=8 → FULL after 8; 9th call jumps, stack_err=1, sp stays 8.
- RET on empty stack at pc=0x05 → pc=0x06, stack_err=1; a later sw_rst clears stack_err and sets pc=0.
- stall held 4 cycles in EXEC during a JMP → pc, instr and instr_valid stable; jump happens on the first cycle with stall=0. rst asserted mid-stall → immediate return to all reset values.
